// File: rtl/seg_display_arbiter_if.sv
// Requester/arbiter bundle for the seven-segment display arbiter: per-requester
// frame requests going in, and the granted frame and handshake pulses coming out.
interface seg_display_arbiter_if;
  logic        Tick;
  logic        Freeze;
  logic [2:0]  Req;
  logic [23:0] ReqData0;
  logic [23:0] ReqData1;
  logic [23:0] ReqData2;
  logic [5:0]  ReqMask0;
  logic [5:0]  ReqMask1;
  logic [5:0]  ReqMask2;
  logic [2:0]  Ack;
  logic [2:0]  Done;
  logic [23:0] Data;
  logic [5:0]  DisplayEnables;
  logic [1:0]  Owner;
  logic        Busy;

  modport master (
    output Tick, Freeze, Req,
    output ReqData0, ReqData1, ReqData2,
    output ReqMask0, ReqMask1, ReqMask2,
    input  Ack, Done, Data, DisplayEnables, Owner, Busy
  );

  modport slave (
    input  Tick, Freeze, Req,
    input  ReqData0, ReqData1, ReqData2,
    input  ReqMask0, ReqMask1, ReqMask2,
    output Ack, Done, Data, DisplayEnables, Owner, Busy
  );
endinterface

// File: rtl/seg_display_arbiter.sv
// Round-robin arbiter granting one of three requesters the seven-segment display
// for HOLD_TICKS Tick pulses; the shown frame stays latched between grants.
module seg_display_arbiter #(
  parameter int unsigned HOLD_TICKS = 4
) (
  input logic                  Clock,
  input logic                  Reset,
  seg_display_arbiter_if.slave bus
);

  localparam logic [15:0] HOLD_TARGET = (HOLD_TICKS == 0) ? 16'd1 : 16'(HOLD_TICKS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_HOLD
  } state_t;

  state_t      r_state;
  logic [1:0]  r_owner;
  logic [2:0]  r_ack;
  logic [2:0]  r_done;
  logic [23:0] r_data;
  logic [5:0]  r_enables;
  logic        r_busy;
  logic [15:0] r_count;

  logic [1:0]  w_winner;
  logic [23:0] w_sel_data;
  logic [5:0]  w_sel_mask;
  logic        w_count_tick;

  assign w_count_tick = bus.Tick && !bus.Freeze;

  // Search starts just after the last owner, so a held request waits its turn.
  always_comb begin
    // NOTE: assign every combinational output a default first so no path infers a latch.
    w_winner = 2'd0;
    case (r_owner)
      2'd0:    w_winner = bus.Req[1] ? 2'd1 : (bus.Req[2] ? 2'd2 : 2'd0);
      2'd1:    w_winner = bus.Req[2] ? 2'd2 : (bus.Req[0] ? 2'd0 : 2'd1);
      default: w_winner = bus.Req[0] ? 2'd0 : (bus.Req[1] ? 2'd1 : 2'd2);
    endcase
  end

  always_comb begin
    w_sel_data = bus.ReqData2;
    w_sel_mask = bus.ReqMask2;
    case (r_owner)
      2'd0: begin
        w_sel_data = bus.ReqData0;
        w_sel_mask = bus.ReqMask0;
      end
      2'd1: begin
        w_sel_data = bus.ReqData1;
        w_sel_mask = bus.ReqMask1;
      end
      default: begin
        w_sel_data = bus.ReqData2;
        w_sel_mask = bus.ReqMask2;
      end
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state   <= S_IDLE;
      r_owner   <= 2'd2;
      r_ack     <= '0;
      r_done    <= '0;
      r_data    <= '0;
      r_enables <= '0;
      r_busy    <= 1'b0;
      r_count   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values.
      r_ack  <= '0;
      r_done <= '0;
      case (r_state)
        S_IDLE: begin
          if (|bus.Req) begin
            r_owner <= w_winner;
            r_ack   <= 3'b001 << w_winner;
            r_busy  <= 1'b1;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_data    <= w_sel_data;
          r_enables <= w_sel_mask;
          r_count   <= '0;
          r_state   <= S_HOLD;
        end
        S_HOLD: begin
          // Ticks arriving while frozen are dropped, never banked.
          if (w_count_tick) begin
            r_count <= r_count + 16'd1;
            if (r_count + 16'd1 == HOLD_TARGET) begin
              r_done  <= 3'b001 << r_owner;
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.Ack            = r_ack;
  assign bus.Done           = r_done;
  assign bus.Data           = r_data;
  assign bus.DisplayEnables = r_enables;
  assign bus.Owner          = r_owner;
  assign bus.Busy           = r_busy;

endmodule

// File: doc/seg_display_arbiter.md
SEG_DISPLAY_ARBITER -- requirements
Module: seg_display_arbiter

Interface
REQ-001 SHALL have parameter HOLD_TICKS, default 4: number of Tick pulses a granted frame stays on the display; value 0 SHALL behave as 1; max 65535.
REQ-002 SHALL have port Clock, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port Reset, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port Tick, input, 1: one-Clock-cycle enable pulse pacing the hold time.
REQ-005 SHALL have port Freeze, input, 1: while high, hold countdown paused.
REQ-006 SHALL have port Req, input, 3: per-requester display request, level.
REQ-007 SHALL have ports ReqData0/1/2, input, 24 each: six hex digits per requester, digit 0 in bits [3:0].
REQ-008 SHALL have ports ReqMask0/1/2, input, 6 each: per-requester digit enables.
REQ-009 SHALL have port Ack, output, 3: one-hot, one-cycle pulse when requester's frame is latched.
REQ-010 SHALL have port Done, output, 3: one-hot, one-cycle pulse when requester's hold time ends.
REQ-011 SHALL have port Data, output, 24: registered frame to the seven-segment scan controller.
REQ-012 SHALL have port DisplayEnables, output, 6: registered digit enables to the scan controller.
REQ-013 SHALL have port Owner, output, 2: index of current/last owner (0..2).
REQ-014 SHALL have port Busy, output, 1: high in LOAD and HOLD.

Function
REQ-015 SHALL implement FSM IDLE, LOAD, HOLD; all outputs registered.
REQ-016 IDLE: if any Req bit high at edge, SHALL select winner round-robin starting from (Owner+1) mod 3, register Owner, go to LOAD; else stay IDLE.
REQ-017 LOAD: Ack[Owner] SHALL be high for exactly this cycle; at the edge leaving LOAD, Data/DisplayEnables SHALL load ReqData/ReqMask of Owner, hold counter SHALL clear, state SHALL go to HOLD.
REQ-018 Requester SHALL keep ReqData/ReqMask stable from Req rise through its Ack cycle; arbiter SHALL ignore them otherwise.
REQ-019 HOLD: 16-bit counter SHALL increment on each cycle with Tick=1 and Freeze=0; Tick in the first HOLD cycle counts.
REQ-020 When a counted Tick brings count to max(HOLD_TICKS,1), state SHALL go to IDLE and Done[Owner] SHALL be high for the first IDLE cycle.
REQ-021 Freeze=1 SHALL block counting and exit from HOLD; Tick pulses during Freeze SHALL be lost, not queued.
REQ-022 Req changes during LOAD/HOLD SHALL not abort or shorten the current frame; owner deasserting Req SHALL have no effect until IDLE.
REQ-023 Data/DisplayEnables SHALL stay unchanged in IDLE (last frame sticky) until the next LOAD exit.
REQ-024 Minimum gap between frames SHALL be one IDLE cycle; Done and next-arbitration occur in the same IDLE cycle.
REQ-025 A requester holding Req continuously SHALL be re-granted only after every other pending requester has been served once.
REQ-026 Latency Req rise (IDLE, no contention) to Ack: 1 cycle; to Data valid: 2 cycles.

Reset
REQ-027 Reset high SHALL immediately force state IDLE, Data=24'h000000, DisplayEnables=6'b000000, Ack=0, Done=0, Busy=0, counter=0, Owner=2 (requester 0 highest priority after reset).
REQ-028 Reset mid-LOAD/HOLD SHALL abort the frame with no Done pulse; arbitration resumes on first edge after Reset falls.

Verification
REQ-029 Reset, Req=3'b001, ReqData0=24'h543210, ReqMask0=6'h3F, HOLD_TICKS=4, Tick every 8 cycles -> Ack=001 cycle 1, Data=24'h543210/DisplayEnables=6'h3F cycle 2, Done=001 after 4th Tick, Data stays 24'h543210.
REQ-030 Req=3'b111 held -> grant order 0,1,2,0; Ack pulses 001,010,100,001; Owner follows.
REQ-031 Freeze high across 3 Tick pulses in HOLD -> count unchanged, Done delayed by exactly those 3 Ticks.
REQ-032 Reset asserted mid-HOLD with Owner=1 -> all outputs at REQ-027 values asynchronously, no Done; Req=3'b010 afterwards -> Ack=010.
REQ-033 HOLD_TICKS=0, Tick every cycle -> HOLD lasts 1 cycle, Done one cycle after entering HOLD.
REQ-034 Owner 0 drops Req in HOLD, Req1 rises -> frame 0 completes full hold, Done=001 and Owner=1 chosen in same IDLE cycle, Ack=010 next cycle.
